serial_test_unit: RTL and testbench

//  Next-generation Test Unit. Examines the accumulator serially, LSB first, during the action beat.

---
 rtl/serial_test_unit_pkg.sv | 31 +++
 rtl/serial_digit_counter.sv | 40 ++++
 rtl/serial_test_unit.sv | 128 ++++++++++++
 tb/tb_serial_test_unit.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/serial_test_unit_pkg.sv
// Shared definitions for the serial test unit: test-mode codes, FSM states,
// counter width derivation and the test-condition evaluator.
package serial_test_unit_pkg;

    localparam logic [1:0] TM_NEG     = 2'b00;
    localparam logic [1:0] TM_ZERO    = 2'b01;
    localparam logic [1:0] TM_NONZERO = 2'b10;
    localparam logic [1:0] TM_ALWAYS  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_EVAL  = 2'b01,
        ST_PEND  = 2'b10,
        ST_APPLY = 2'b11
    } stu_state_e;

    function automatic int unsigned cnt_width(input int unsigned bits);
        return (bits > 1) ? $clog2(bits) : 1;
    endfunction

    // msb is the last (most significant) digit; zf covers every digit of the word
    function automatic logic test_pass(input logic [1:0] mode, input logic msb, input logic zf);
        case (mode)
            TM_NEG:     return msb;
            TM_ZERO:    return zf;
            TM_NONZERO: return ~zf;
            default:    return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/serial_digit_counter.sv
// Digit index tracker for LSB-first serial words; index 0 is presented
// combinationally on the word-start strobe itself.
module serial_digit_counter
    import serial_test_unit_pkg::*;
#(
    parameter int unsigned WORD_BITS = 32,
    parameter int unsigned CNT_W     = cnt_width(WORD_BITS)
) (
    input  logic             w_CLK,
    input  logic             w_RST_N,
    input  logic             w_BIT_STROBE,
    input  logic             w_WORD_START,
    output logic [CNT_W-1:0] w_IDX,
    output logic             w_LAST_DIGIT
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORD_BITS - 1);
    localparam logic [CNT_W-1:0] ONE_IDX  = (WORD_BITS > 1) ? CNT_W'(1) : '0;

    logic [CNT_W-1:0] cnt_q;
    logic             word_start;

    assign word_start   = w_BIT_STROBE & w_WORD_START;
    assign w_IDX        = word_start ? '0 : cnt_q;
    assign w_LAST_DIGIT = w_BIT_STROBE & (w_IDX == LAST_IDX);

    always_ff @(posedge w_CLK or negedge w_RST_N) begin
        if (!w_RST_N) begin
            cnt_q <= '0;
        end else if (w_BIT_STROBE) begin
            if (word_start)
                cnt_q <= ONE_IDX;
            else if (cnt_q == LAST_IDX)
                cnt_q <= '0;
            else
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/serial_test_unit.sv
// Serial test unit: evaluates the accumulator during the action beat and
// streams the CI increment operand (1, or 1+SKIP_STEP after a pass).
module serial_test_unit
    import serial_test_unit_pkg::*;
#(
    parameter int unsigned WORD_BITS = 32,
    parameter int unsigned SKIP_STEP = 1
) (
    input  logic       w_CLK,
    input  logic       w_RST_N,
    input  logic       w_BIT_STROBE,
    input  logic       w_WORD_START,
    input  logic       w_ACC_DIGIT,
    input  logic       w_ACTION_BEAT,
    input  logic       w_TEST_EN,
    input  logic [1:0] w_TEST_MODE,
    input  logic       w_INCR_BEAT,
    output logic       w_INCR_DIGIT,
    output logic       w_SKIP_PENDING,
    output logic       w_TEST_RESULT,
    output logic       w_ERR
);

    localparam int unsigned CNT_W = cnt_width(WORD_BITS);
    localparam logic [WORD_BITS-1:0] INC_ONE  = WORD_BITS'(1);
    localparam logic [WORD_BITS-1:0] INC_SKIP = WORD_BITS'(1 + SKIP_STEP);

    stu_state_e       state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic             zf_q, zf_d;
    logic             result_q, result_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] idx;
    logic             last_digit;
    logic             word_start;
    logic             beat_clash;
    logic             test_start;
    logic             zf_acc;
    logic             pass;
    logic             skip_active;

    serial_digit_counter #(
        .WORD_BITS (WORD_BITS),
        .CNT_W     (CNT_W)
    ) u_counter (
        .w_CLK        (w_CLK),
        .w_RST_N      (w_RST_N),
        .w_BIT_STROBE (w_BIT_STROBE),
        .w_WORD_START (w_WORD_START),
        .w_IDX        (idx),
        .w_LAST_DIGIT (last_digit)
    );

    assign word_start = w_BIT_STROBE & w_WORD_START;
    assign beat_clash = word_start & w_ACTION_BEAT & w_INCR_BEAT;
    assign test_start = word_start & w_ACTION_BEAT & w_TEST_EN;
    assign zf_acc     = zf_q & ~w_ACC_DIGIT;
    assign pass       = test_pass(mode_q, w_ACC_DIGIT, zf_acc);

    always_ff @(posedge w_CLK or negedge w_RST_N) begin
        if (!w_RST_N) begin
            state_q  <= ST_IDLE;
            mode_q   <= '0;
            zf_q     <= 1'b0;
            result_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            zf_q     <= zf_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        zf_d     = zf_q;
        result_d = result_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                if (beat_clash) begin
                    err_d = 1'b1;
                end else if (test_start) begin
                    state_d = ST_EVAL;
                    mode_d  = w_TEST_MODE;
                    zf_d    = ~w_ACC_DIGIT;
                end
            end
            ST_EVAL: begin
                // A new word start here means the word ended early: abort.
                if (!w_ACTION_BEAT || word_start) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else if (w_BIT_STROBE) begin
                    zf_d = zf_acc;
                    if (last_digit) begin
                        result_d = pass;
                        state_d  = pass ? ST_PEND : ST_IDLE;
                    end
                end
            end
            ST_PEND: begin
                if (beat_clash)
                    err_d = 1'b1;
                else if (word_start && w_INCR_BEAT)
                    state_d = ST_APPLY;
                else if (test_start)
                    err_d = 1'b1;
            end
            ST_APPLY: begin
                if (last_digit)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign skip_active    = (state_q == ST_PEND) || (state_q == ST_APPLY);
    assign w_INCR_DIGIT   = w_INCR_BEAT & w_BIT_STROBE &
                            (skip_active ? INC_SKIP[idx] : INC_ONE[idx]);
    assign w_SKIP_PENDING = skip_active;
    assign w_TEST_RESULT  = result_q;
    assign w_ERR          = err_q;

endmodule

// File: tb/tb_serial_test_unit.sv
// Scoreboard bench for serial_test_unit (WORD_BITS=8, SKIP_STEP=1).
module tb_serial_test_unit;
    import serial_test_unit_pkg::*;

    localparam int unsigned WB = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       strobe = 1'b0;
    logic       word_start = 1'b0;
    logic       acc_digit = 1'b0;
    logic       action = 1'b0;
    logic       test_en = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       incr = 1'b0;
    logic       incr_digit;
    logic       skip_pending;
    logic       test_result;
    logic       err;

    int unsigned n_checks = 0;
    int unsigned n_pass = 0;
    logic [7:0]  sb_q[$];
    logic        exp_result;

    serial_test_unit #(
        .WORD_BITS (WB),
        .SKIP_STEP (1)
    ) dut (
        .w_CLK          (clk),
        .w_RST_N        (rst_n),
        .w_BIT_STROBE   (strobe),
        .w_WORD_START   (word_start),
        .w_ACC_DIGIT    (acc_digit),
        .w_ACTION_BEAT  (action),
        .w_TEST_EN      (test_en),
        .w_TEST_MODE    (mode),
        .w_INCR_BEAT    (incr),
        .w_INCR_DIGIT   (incr_digit),
        .w_SKIP_PENDING (skip_pending),
        .w_TEST_RESULT  (test_result),
        .w_ERR          (err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Collect the serial increment operand and compare whole words with the scoreboard.
    logic [7:0] mon_word = '0;
    int unsigned mon_n = 0;
    always @(negedge clk) begin
        if (incr && strobe) begin
            if (word_start)
                mon_n = 0;
            if (mon_n < WB)
                mon_word[mon_n] = incr_digit;
            mon_n++;
            if (mon_n == WB) begin
                if (sb_q.size() == 0)
                    check_val("incr_unexpected", sb_q.size(), 1);
                else
                    check_val("incr_value", mon_word, sb_q.pop_front());
                mon_n = 0;
            end
        end
    end

    task automatic drive_word(input logic act, input logic ten, input logic [1:0] md,
                              input logic inc, input logic [7:0] data, input int unsigned nbits,
                              input logic exp_skip, input logic chk_skip);
        action  = act;
        test_en = ten;
        mode    = md;
        incr    = inc;
        for (int unsigned i = 0; i < nbits; i++) begin
            @(posedge clk); #1;
            strobe     = 1'b1;
            word_start = (i == 0);
            acc_digit  = data[i];
            @(negedge clk);
            if (chk_skip)
                check_val("skip_during_incr", skip_pending, exp_skip);
            @(posedge clk); #1;
            strobe     = 1'b0;
            word_start = 1'b0;
            acc_digit  = 1'b0;
        end
    endtask

    task automatic end_beat();
        action  = 1'b0;
        test_en = 1'b0;
        incr    = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_word(input logic [1:0] md, input logic [7:0] data);
        drive_word(1'b1, 1'b1, md, 1'b0, data, WB, 1'b0, 1'b0);
        end_beat();
    endtask

    task automatic incr_word(input logic [7:0] expv, input logic exp_skip);
        sb_q.push_back(expv);
        drive_word(1'b0, 1'b0, 2'b00, 1'b1, 8'h00, WB, exp_skip, 1'b1);
        end_beat();
        check_val("skip_after_incr", skip_pending, 1'b0);
    endtask

    initial begin
        #2;
        check_val("rst_incr_digit", incr_digit, 1'b0);
        check_val("rst_skip", skip_pending, 1'b0);
        check_val("rst_result", test_result, 1'b0);
        check_val("rst_err", err, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        exp_result = 1'b0;

        test_word(TM_NEG, 8'h80);
        exp_result = 1'b1;
        check_val("neg80_result", test_result, exp_result);
        check_val("neg80_skip", skip_pending, 1'b1);
        incr_word(8'd2, 1'b1);

        test_word(TM_NEG, 8'h7F);
        exp_result = 1'b0;
        check_val("neg7f_result", test_result, exp_result);
        check_val("neg7f_skip", skip_pending, 1'b0);
        incr_word(8'd1, 1'b0);

        test_word(TM_ZERO, 8'h00);
        exp_result = 1'b1;
        check_val("zero00_result", test_result, exp_result);
        incr_word(8'd2, 1'b1);

        test_word(TM_NONZERO, 8'h00);
        exp_result = 1'b0;
        check_val("nz00_result", test_result, exp_result);
        check_val("nz00_skip", skip_pending, 1'b0);
        incr_word(8'd1, 1'b0);

        test_word(TM_ALWAYS, 8'h5A);
        exp_result = 1'b1;
        check_val("always_result", test_result, exp_result);
        check_val("always_skip", skip_pending, 1'b1);
        incr_word(8'd2, 1'b1);
        check_val("err_clean", err, 1'b0);

        // Early word start at digit 4 inside a continuous action beat.
        drive_word(1'b1, 1'b1, TM_ALWAYS, 1'b0, 8'hFF, 4, 1'b0, 1'b0);
        drive_word(1'b1, 1'b0, TM_ALWAYS, 1'b0, 8'hFF, WB, 1'b0, 1'b0);
        end_beat();
        check_val("abort_err", err, 1'b1);
        check_val("abort_skip", skip_pending, 1'b0);
        check_val("abort_result", test_result, exp_result);
        incr_word(8'd1, 1'b0);

        test_word(TM_ALWAYS, 8'h00);
        check_val("prerst_skip", skip_pending, 1'b1);
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        exp_result = 1'b0;
        check_val("midrst_skip", skip_pending, 1'b0);
        check_val("midrst_result", test_result, exp_result);
        check_val("midrst_err", err, 1'b0);
        check_val("midrst_incr_digit", incr_digit, 1'b0);
        @(posedge clk); #1 rst_n = 1'b1;
        incr_word(8'd1, 1'b0);

        test_word(TM_ALWAYS, 8'h11);
        exp_result = 1'b1;
        test_word(TM_ZERO, 8'h01);
        check_val("dbl_err", err, 1'b1);
        check_val("dbl_skip", skip_pending, 1'b1);
        check_val("dbl_result", test_result, exp_result);
        incr_word(8'd2, 1'b1);
        incr_word(8'd1, 1'b0);

        repeat (4) @(posedge clk);
        check_val("sb_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
